axi_burst_master: RTL
=====================

Name: axi_burst_master

Overview:
- AXI initiator (master) driving the write-address, write-data, read-address and read-data channels of the team's AXI interface.
- Pairs with the existing responder BFM, which drives the READY signals and read data.
- Accepts one burst command at a time from a local command port and sources write data from a local stream.
- Delivers read data to a local sink. There is no write-response channel and there are no IDs.

Parameters:
- ADD_SIZE, 32, address width
- DATA_SIZE, 32, data width
- LEN_SIZE, 4, burst length field width (beats = LEN+1)
- S_SIZE, 3, burst size field width
- BURST_SIZE, 2, burst type field width

Ports:
- ACLK  in  1  clock, all logic on posedge
- ARESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADD_SIZE  start address
- cmd_len  in  LEN_SIZE  beats-1
- cmd_size  in  S_SIZE  passed to AxSIZE
- cmd_burst  in  BURST_SIZE  passed to AxBURST
- wd_data  in  DATA_SIZE  write data stream
- wd_valid  in  1  write data available
- wd_ready  out  1  write data consumed
- rd_data  out  DATA_SIZE  read data to sink
- rd_valid  out  1  read beat valid
- rd_last  out  1  final read beat
- rd_ready  in  1  sink can accept
- done  out  1  one-cycle pulse at burst completion
- AWADDR/AWLEN/AWSIZE/AWBURST  out  ADD_SIZE/LEN_SIZE/S_SIZE/BURST_SIZE  write address
- AWVALID  out  1;  AWREADY  in  1
- WDATA  out  DATA_SIZE;  WLAST  out  1;  WVALID  out  1;  WREADY  in  1
- ARADDR/ARLEN/ARSIZE/ARBURST  out  widths as AW
- ARVALID  out  1;  ARREADY  in  1
- RDATA  in  DATA_SIZE;  RLAST  in  1;  RVALID  in  1;  RREADY  out  1

Behaviour:
- Reset (ARESET high at posedge):
  - state=IDLE, beat_cnt=0.
  - All VALID/READY/LAST outputs, done and cmd_ready are 0.
  - Address, len, size, burst and data outputs are 0.
- States and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, latch all cmd fields and go to WR_ADDR (cmd_write=1) or RD_ADDR (cmd_write=0).
  - WR_ADDR: AWVALID=1 from the cycle after acceptance; AW fields hold the latched values. On AWREADY, AWVALID drops and the block goes to WR_DATA.
  - WR_DATA:
    - WVALID=wd_valid, WDATA=wd_data, wd_ready=WREADY, WLAST=(beat_cnt==len).
    - Each cycle with WVALID&&WREADY increments beat_cnt.
    - The beat with WLAST ends the burst: done pulses for one cycle, beat_cnt returns to 0, state returns to IDLE.
  - RD_ADDR: same as WR_ADDR on the AR channel; on ARREADY go to RD_DATA.
  - RD_DATA:
    - RREADY=rd_ready, rd_valid=RVALID, rd_data=RDATA, rd_last=(beat_cnt==len).
    - Each RVALID&&RREADY beat increments beat_cnt.
    - The beat with beat_cnt==len ends the burst: done pulses, state returns to IDLE.
- Handshake rules:
  - Once asserted, AWVALID and ARVALID stay high with stable fields until READY.
  - WVALID, once high, is never withdrawn before WREADY. wd_valid must therefore hold while WREADY is low; the local source is responsible for this.
  - READY may be high before VALID. A transfer completes in the same cycle that VALID and READY are both high.
- Latency:
  - cmd accept to AWVALID/ARVALID: 1 cycle.
  - Address handshake to first data-phase cycle: 1 cycle.
  - Burst end to cmd_ready=1 again: 1 cycle, in the same cycle as done.
- Boundaries:
  - cmd_len=0: single beat, WLAST and rd_last high on the first beat.
  - cmd_len=2^LEN_SIZE-1: 16 beats; beat_cnt is LEN_SIZE bits and does not overflow before termination.
  - The address is not incremented locally; address generation for INCR/WRAP bursts belongs to the slave.
  - Burst termination counts beats; the RLAST input does not terminate the burst.
  - Read and write bursts are never concurrent.
  - ARESET mid-burst: abandon the burst, go to IDLE, drop all VALIDs next edge; done is not pulsed.

Optional Feature:
- Macro: AXI_MST_PROTOCOL_CHECK_EN.
- With the macro defined:
  - Adds output prot_err (1 bit, sticky, cleared only by ARESET).
  - prot_err sets when RLAST on an accepted read beat disagrees with (beat_cnt==len).
  - prot_err sets when AWREADY or ARREADY is sampled high outside its address state while no VALID is pending.
- Without the macro, the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Write len=3, addr=0x100, size=2, burst=1, AWREADY after 2 cycles, WREADY always 1, data 0xA0..0xA3 -> AWADDR=0x100, AWLEN=3 held until AWREADY; 4 W beats with WLAST only on 0xA3; done pulses once.
- Read len=0, ARREADY immediate, RVALID with 0x55 -> rd_valid with rd_data=0x55 and rd_last=1; done pulses; cmd_ready=1 the same cycle.
- Read len=7, rd_ready toggling 1/0 each cycle -> RREADY mirrors rd_ready; exactly 8 beats accepted; rd_last on the 8th.
- Write len=15 with WREADY deasserted on beats 5 and 10 -> WVALID/WDATA stable across stalls; 16 beats; WLAST only on beat 15.
- ARESET pulse during beat 2 of a len=3 write -> next edge all VALIDs 0, state IDLE, no done; a new command is accepted afterward.
- With AXI_MST_PROTOCOL_CHECK_EN: read len=3 with RLAST on beat 2 -> prot_err=1 and stays 1 until ARESET; the burst still ends after 4 beats.

Source files
------------

// File: rtl/axi_burst_master.sv
// -----------------------------------------------------------------------------
// axi_burst_master
//
// Purpose:
//   AXI initiator that runs one burst at a time on the write-address,
//   write-data, read-address and read-data channels. A burst command is taken
//   from a local command port. Write beats come from a local stream and read
//   beats go to a local sink. There is no write-response channel and no IDs.
//   The burst ends when the local beat count reaches len. RLAST does not end a
//   burst. Addresses are not incremented locally, because the slave generates
//   INCR/WRAP addresses.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   cmd_*                 command request/accept, direction, addr, len, size,
//                         burst type
//   wd_data/valid/ready   local write-data stream
//   rd_data/valid/last    local read-data sink (rd_ready back-pressure)
//   done                  one-cycle pulse when a burst completes
//   AW*/W*                AXI write address and write data channels
//   AR*/R*                AXI read address and read data channels
//   prot_err              sticky protocol-violation flag (optional)
//
// Optional feature:
//   AXI_MST_PROTOCOL_CHECK_EN adds prot_err. It flags an RLAST that disagrees
//   with the beat count, and it flags an AWREADY/ARREADY that arrives with no
//   address pending.
// -----------------------------------------------------------------------------
module axi_burst_master #(
   parameter int ADD_SIZE   = 32,
   parameter int DATA_SIZE  = 32,
   parameter int LEN_SIZE   = 4,
   parameter int S_SIZE     = 3,
   parameter int BURST_SIZE = 2
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADD_SIZE-1:0]   cmd_addr,
   input  logic [LEN_SIZE-1:0]   cmd_len,
   input  logic [S_SIZE-1:0]     cmd_size,
   input  logic [BURST_SIZE-1:0] cmd_burst,
   input  logic [DATA_SIZE-1:0]  wd_data,
   input  logic                  wd_valid,
   output logic                  wd_ready,
   output logic [DATA_SIZE-1:0]  rd_data,
   output logic                  rd_valid,
   output logic                  rd_last,
   input  logic                  rd_ready,
   output logic                  done,
   output logic [ADD_SIZE-1:0]   AWADDR,
   output logic [LEN_SIZE-1:0]   AWLEN,
   output logic [S_SIZE-1:0]     AWSIZE,
   output logic [BURST_SIZE-1:0] AWBURST,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   output logic [DATA_SIZE-1:0]  WDATA,
   output logic                  WLAST,
   output logic                  WVALID,
   input  logic                  WREADY,
   output logic [ADD_SIZE-1:0]   ARADDR,
   output logic [LEN_SIZE-1:0]   ARLEN,
   output logic [S_SIZE-1:0]     ARSIZE,
   output logic [BURST_SIZE-1:0] ARBURST,
   output logic                  ARVALID,
   input  logic                  ARREADY,
   input  logic [DATA_SIZE-1:0]  RDATA,
   input  logic                  RLAST,
   input  logic                  RVALID,
   output logic                  RREADY
`ifdef AXI_MST_PROTOCOL_CHECK_EN
   ,
   output logic                  prot_err
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_ADDR,
      S_WR_DATA,
      S_RD_ADDR,
      S_RD_DATA
   } state_t;

   state_t                state_q;
   logic [LEN_SIZE-1:0]   beat_cnt_q;
   logic [ADD_SIZE-1:0]   addr_q;
   logic [LEN_SIZE-1:0]   len_q;
   logic [S_SIZE-1:0]     size_q;
   logic [BURST_SIZE-1:0] burst_q;
   logic                  awvalid_q;
   logic                  arvalid_q;
   logic                  done_q;
   logic                  cmd_ready_q;

   logic in_wr_data;
   logic in_rd_data;
   logic last_beat;
   logic w_fire;
   logic r_fire;

   assign in_wr_data = (state_q == S_WR_DATA);
   assign in_rd_data = (state_q == S_RD_DATA);
   assign last_beat  = (beat_cnt_q == len_q);
   assign w_fire     = in_wr_data && wd_valid && WREADY;
   assign r_fire     = in_rd_data && RVALID && rd_ready;

   // The address channels show the latched command for the whole burst.
   // Only the direction-specific VALID is ever raised.
   assign AWADDR  = addr_q;
   assign AWLEN   = len_q;
   assign AWSIZE  = size_q;
   assign AWBURST = burst_q;
   assign AWVALID = awvalid_q;
   assign ARADDR  = addr_q;
   assign ARLEN   = len_q;
   assign ARSIZE  = size_q;
   assign ARBURST = burst_q;
   assign ARVALID = arvalid_q;

   // The data phases are pass-through, gated by state. This keeps the local
   // stream and the AXI channel in the same cycle with no extra buffering.
   // Holding WVALID until WREADY is therefore the job of the local source.
   assign WVALID   = in_wr_data && wd_valid;
   assign WDATA    = in_wr_data ? wd_data : '0;
   assign WLAST    = in_wr_data && last_beat;
   assign wd_ready = in_wr_data && WREADY;

   assign RREADY   = in_rd_data && rd_ready;
   assign rd_valid = in_rd_data && RVALID;
   assign rd_data  = in_rd_data ? RDATA : '0;
   assign rd_last  = in_rd_data && last_beat;

   assign done      = done_q;
   assign cmd_ready = cmd_ready_q;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= S_IDLE;
         beat_cnt_q  <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         awvalid_q   <= 1'b0;
         arvalid_q   <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  addr_q      <= cmd_addr;
                  len_q       <= cmd_len;
                  size_q      <= cmd_size;
                  burst_q     <= cmd_burst;
                  beat_cnt_q  <= '0;
                  cmd_ready_q <= 1'b0;
                  if (cmd_write) begin
                     state_q   <= S_WR_ADDR;
                     awvalid_q <= 1'b1;
                  end else begin
                     state_q   <= S_RD_ADDR;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            S_WR_ADDR: begin
               if (AWREADY) begin
                  awvalid_q <= 1'b0;
                  state_q   <= S_WR_DATA;
               end
            end
            S_WR_DATA: begin
               if (w_fire) begin
                  if (last_beat) begin
                     beat_cnt_q  <= '0;
                     done_q      <= 1'b1;
                     cmd_ready_q <= 1'b1;
                     state_q     <= S_IDLE;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            S_RD_ADDR: begin
               if (ARREADY) begin
                  arvalid_q <= 1'b0;
                  state_q   <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               // The local beat count ends the burst. RLAST is not used here.
               if (r_fire) begin
                  if (last_beat) begin
                     beat_cnt_q  <= '0;
                     done_q      <= 1'b1;
                     cmd_ready_q <= 1'b1;
                     state_q     <= S_IDLE;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q     <= S_IDLE;
               awvalid_q   <= 1'b0;
               arvalid_q   <= 1'b0;
               cmd_ready_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef AXI_MST_PROTOCOL_CHECK_EN
   logic prot_err_q;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         prot_err_q <= 1'b0;
      end else begin
         if (r_fire && (RLAST != last_beat)) begin
            prot_err_q <= 1'b1;
         end
         if (AWREADY && (state_q != S_WR_ADDR) && !awvalid_q) begin
            prot_err_q <= 1'b1;
         end
         if (ARREADY && (state_q != S_RD_ADDR) && !arvalid_q) begin
            prot_err_q <= 1'b1;
         end
      end
   end

   assign prot_err = prot_err_q;
`else
   // RLAST only feeds the optional checker.
   logic unused_rlast;
   assign unused_rlast = RLAST;
`endif

endmodule
